// File: rtl/dircc_stream_address_router.sv
// Ingress demultiplexer: steers each network packet to the local tile, the forward
// port, or both, based on its header beat. Routes stay locked from sop to eop.
module dircc_stream_address_router #(
  parameter bit          BROADCAST_EN   = 1'b1,
  parameter logic [31:0] BROADCAST_ADDR = 32'hFFFFFFFF,
  parameter int          DROP_CNT_WIDTH = 16
) (
  input  logic                      clk_routing_clk,
  input  logic                      reset_routing_reset_n,
  input  logic [31:0]               address_address,

  input  logic                      net_in_valid,
  input  logic [31:0]               net_in_data,
  input  logic                      net_in_startofpacket,
  input  logic                      net_in_endofpacket,
  input  logic [1:0]                net_in_empty,
  output logic                      net_in_ready,

  output logic                      local_out_valid,
  output logic [31:0]               local_out_data,
  output logic                      local_out_startofpacket,
  output logic                      local_out_endofpacket,
  output logic [1:0]                local_out_empty,
  input  logic                      local_out_ready,

  output logic                      fwd_out_valid,
  output logic [31:0]               fwd_out_data,
  output logic                      fwd_out_startofpacket,
  output logic                      fwd_out_endofpacket,
  output logic [1:0]                fwd_out_empty,
  input  logic                      fwd_out_ready,

  output logic [DROP_CNT_WIDTH-1:0] drop_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TO_LOCAL = 2'd1,
    TO_FWD   = 2'd2,
    TO_BOTH  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    R_DROP  = 2'd0,
    R_LOCAL = 2'd1,
    R_FWD   = 2'd2,
    R_BOTH  = 2'd3
  } route_t;

  state_t                    state_q, state_d;
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;

  route_t hdr_route;
  route_t route;
  state_t hdr_state;
  logic   local_valid;
  logic   fwd_valid;
  logic   in_ready;
  logic   accept;
  logic   drop_inc;

  // Payload is shared by both outputs; only the handshake is steered.
  assign local_out_data          = net_in_data;
  assign local_out_startofpacket = net_in_startofpacket;
  assign local_out_endofpacket   = net_in_endofpacket;
  assign local_out_empty         = net_in_empty;
  assign fwd_out_data            = net_in_data;
  assign fwd_out_startofpacket   = net_in_startofpacket;
  assign fwd_out_endofpacket     = net_in_endofpacket;
  assign fwd_out_empty           = net_in_empty;

  always_comb begin
    if (BROADCAST_EN && (net_in_data == BROADCAST_ADDR)) begin
      hdr_route = R_BOTH;
      hdr_state = TO_BOTH;
    end else if (net_in_data == address_address) begin
      hdr_route = R_LOCAL;
      hdr_state = TO_LOCAL;
    end else begin
      hdr_route = R_FWD;
      hdr_state = TO_FWD;
    end
  end

  // In IDLE the header is classified on the fly; a non-sop beat has nowhere to go.
  always_comb begin
    route = R_DROP;
    case (state_q)
      IDLE:     route = net_in_startofpacket ? hdr_route : R_DROP;
      TO_LOCAL: route = R_LOCAL;
      TO_FWD:   route = R_FWD;
      TO_BOTH:  route = R_BOTH;
      default:  route = R_DROP;
    endcase
  end

  always_comb begin
    local_valid = 1'b0;
    fwd_valid   = 1'b0;
    in_ready    = 1'b0;
    case (route)
      R_DROP: begin
        in_ready = 1'b1;
      end
      R_LOCAL: begin
        local_valid = net_in_valid;
        in_ready    = local_out_ready;
      end
      R_FWD: begin
        fwd_valid = net_in_valid;
        in_ready  = fwd_out_ready;
      end
      R_BOTH: begin
        // Cross-qualified valids keep the two copies in lockstep.
        local_valid = net_in_valid && fwd_out_ready;
        fwd_valid   = net_in_valid && local_out_ready;
        in_ready    = local_out_ready && fwd_out_ready;
      end
      default: begin
        in_ready = 1'b1;
      end
    endcase
  end

  assign local_out_valid = local_valid && reset_routing_reset_n;
  assign fwd_out_valid   = fwd_valid && reset_routing_reset_n;
  assign net_in_ready    = in_ready && reset_routing_reset_n;

  assign accept   = net_in_valid && net_in_ready;
  assign drop_inc = accept && (route == R_DROP);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && net_in_startofpacket && !net_in_endofpacket) begin
          state_d = hdr_state;
        end
      end
      TO_LOCAL, TO_FWD, TO_BOTH: begin
        if (accept && net_in_endofpacket) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    drop_d = drop_q;
    if (drop_inc && (drop_q != {DROP_CNT_WIDTH{1'b1}})) begin
      drop_d = drop_q + DROP_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_routing_clk or negedge reset_routing_reset_n) begin
    if (!reset_routing_reset_n) begin
      state_q <= IDLE;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  assign drop_count = drop_q;

endmodule

// File: tb/tb_dircc_stream_address_router.sv
// Bench for dircc_stream_address_router: directed scenarios then random packets,
// checked against a packet-level scoreboard of expected local/forward beats.
module tb_dircc_stream_address_router;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] address_address = 32'h0;
  logic        net_in_valid = 1'b0;
  logic [31:0] net_in_data = 32'h0;
  logic        net_in_startofpacket = 1'b0;
  logic        net_in_endofpacket = 1'b0;
  logic [1:0]  net_in_empty = 2'd0;
  logic        net_in_ready;
  logic        local_out_valid, local_out_startofpacket, local_out_endofpacket;
  logic [31:0] local_out_data;
  logic [1:0]  local_out_empty;
  logic        local_out_ready = 1'b0;
  logic        fwd_out_valid, fwd_out_startofpacket, fwd_out_endofpacket;
  logic [31:0] fwd_out_data;
  logic [1:0]  fwd_out_empty;
  logic        fwd_out_ready = 1'b0;
  logic [15:0] drop_count;

  logic        s_net_in_ready, s_local_out_valid, s_local_out_sop, s_local_out_eop;
  logic        s_fwd_out_valid, s_fwd_out_sop, s_fwd_out_eop;
  logic [31:0] s_local_out_data, s_fwd_out_data;
  logic [1:0]  s_local_out_empty, s_fwd_out_empty;
  logic [1:0]  s_drop_count;

  always #5 clk = ~clk;

  dircc_stream_address_router u_dut (
    .clk_routing_clk(clk), .reset_routing_reset_n(rst_n), .address_address(address_address),
    .net_in_valid(net_in_valid), .net_in_data(net_in_data),
    .net_in_startofpacket(net_in_startofpacket), .net_in_endofpacket(net_in_endofpacket),
    .net_in_empty(net_in_empty), .net_in_ready(net_in_ready),
    .local_out_valid(local_out_valid), .local_out_data(local_out_data),
    .local_out_startofpacket(local_out_startofpacket), .local_out_endofpacket(local_out_endofpacket),
    .local_out_empty(local_out_empty), .local_out_ready(local_out_ready),
    .fwd_out_valid(fwd_out_valid), .fwd_out_data(fwd_out_data),
    .fwd_out_startofpacket(fwd_out_startofpacket), .fwd_out_endofpacket(fwd_out_endofpacket),
    .fwd_out_empty(fwd_out_empty), .fwd_out_ready(fwd_out_ready),
    .drop_count(drop_count)
  );

  // Narrow-counter instance sees identical traffic; only its drop_count is checked.
  dircc_stream_address_router #(.DROP_CNT_WIDTH(2)) u_sat (
    .clk_routing_clk(clk), .reset_routing_reset_n(rst_n), .address_address(address_address),
    .net_in_valid(net_in_valid), .net_in_data(net_in_data),
    .net_in_startofpacket(net_in_startofpacket), .net_in_endofpacket(net_in_endofpacket),
    .net_in_empty(net_in_empty), .net_in_ready(s_net_in_ready),
    .local_out_valid(s_local_out_valid), .local_out_data(s_local_out_data),
    .local_out_startofpacket(s_local_out_sop), .local_out_endofpacket(s_local_out_eop),
    .local_out_empty(s_local_out_empty), .local_out_ready(local_out_ready),
    .fwd_out_valid(s_fwd_out_valid), .fwd_out_data(s_fwd_out_data),
    .fwd_out_startofpacket(s_fwd_out_sop), .fwd_out_endofpacket(s_fwd_out_eop),
    .fwd_out_empty(s_fwd_out_empty), .fwd_out_ready(fwd_out_ready),
    .drop_count(s_drop_count)
  );

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
    logic [31:0] data;
  } beat_t;

  beat_t exp_l[$], exp_f[$], got_l[$], got_f[$];
  int    total = 0;
  int    bad = 0;
  int    model_drops = 0;
  int    split_err = 0;
  bit    bcast_active = 1'b0;
  bit    rand_rdy = 1'b1;
  bit    chk_mirror = 1'b0;
  bit    lr_pat[$], fr_pat[$];
  logic  ltx, ftx;

  always @(negedge clk) begin
    if (rst_n) begin
      ltx = local_out_valid && local_out_ready;
      ftx = fwd_out_valid && fwd_out_ready;
      if (ltx) got_l.push_back({local_out_startofpacket, local_out_endofpacket, local_out_empty, local_out_data});
      if (ftx) got_f.push_back({fwd_out_startofpacket, fwd_out_endofpacket, fwd_out_empty, fwd_out_data});
      if (bcast_active && (ltx != ftx)) split_err++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t mk(input logic [31:0] d, input logic s, input logic e, input logic [1:0] em);
    beat_t b;
    b.sop = s; b.eop = e; b.empty = em; b.data = d;
    return b;
  endfunction

  task automatic drive_rdy();
    if (lr_pat.size() > 0) local_out_ready = lr_pat.pop_front();
    else if (rand_rdy) local_out_ready = ($urandom_range(0, 3) != 0);
    if (fr_pat.size() > 0) fwd_out_ready = fr_pat.pop_front();
    else if (rand_rdy) fwd_out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_beat(input beat_t b, output int cyc);
    logic acc;
    acc = 1'b0;
    cyc = 0;
    net_in_valid = 1'b1;
    net_in_data = b.data;
    net_in_startofpacket = b.sop;
    net_in_endofpacket = b.eop;
    net_in_empty = b.empty;
    while (!acc && cyc < 200) begin
      drive_rdy();
      @(negedge clk);
      acc = net_in_ready;
      if (chk_mirror) check("ready_mirrors_fwd", net_in_ready, fwd_out_ready);
      @(posedge clk); #1;
      cyc++;
    end
    net_in_valid = 1'b0;
    check("beat_accepted", acc, 1);
  endtask

  task automatic xmit(input beat_t b, input bit to_l, input bit to_f, output int cyc);
    if (to_l) exp_l.push_back(b);
    if (to_f) exp_f.push_back(b);
    send_beat(b, cyc);
  endtask

  task automatic send_drop(input logic [31:0] d);
    net_in_valid = 1'b1;
    net_in_data = d;
    net_in_startofpacket = 1'b0;
    net_in_endofpacket = 1'($urandom_range(0, 1));
    net_in_empty = 2'($urandom_range(0, 3));
    drive_rdy();
    @(negedge clk);
    check("drop_ready", net_in_ready, 1);
    check("drop_local_valid", local_out_valid, 0);
    check("drop_fwd_valid", fwd_out_valid, 0);
    @(posedge clk); #1;
    net_in_valid = 1'b0;
    model_drops++;
  endtask

  // Routes are chosen from the header and the address at header time only.
  task automatic send_packet(input logic [31:0] hdr, input int len, input bit scramble);
    bit    bc, loc;
    beat_t b;
    int    c;
    bc = (hdr == 32'hFFFFFFFF);
    loc = !bc && (hdr == address_address);
    bcast_active = bc;
    for (int i = 0; i < len; i++) begin
      b.sop = (i == 0) || ((i < len - 1) && ($urandom_range(0, 7) == 0));
      b.eop = (i == len - 1);
      b.empty = b.eop ? 2'($urandom_range(0, 3)) : 2'd0;
      b.data = (i == 0) ? hdr : $urandom;
      xmit(b, loc || bc, !loc, c);
      if (i == 0 && scramble) address_address = $urandom;
    end
    bcast_active = 1'b0;
  endtask

  task automatic cmp_queues(input string tag);
    int n;
    check({tag, "_local_count"}, 64'(got_l.size()), 64'(exp_l.size()));
    check({tag, "_fwd_count"}, 64'(got_f.size()), 64'(exp_f.size()));
    n = (got_l.size() < exp_l.size()) ? got_l.size() : exp_l.size();
    for (int i = 0; i < n; i++) check({tag, "_local_beat"}, 64'(got_l[i]), 64'(exp_l[i]));
    n = (got_f.size() < exp_f.size()) ? got_f.size() : exp_f.size();
    for (int i = 0; i < n; i++) check({tag, "_fwd_beat"}, 64'(got_f[i]), 64'(exp_f[i]));
    got_l.delete(); got_f.delete(); exp_l.delete(); exp_f.delete();
  endtask

  task automatic check_drops(input string tag);
    check({tag, "_drop_count"}, 64'(drop_count), 64'(model_drops));
    check({tag, "_drop_count_sat"}, 64'(s_drop_count), 64'((model_drops > 3) ? 3 : model_drops));
  endtask

  initial begin
    int c;
    int kind;
    logic [31:0] hdr;

    // Reset: outputs stay quiet even with a header presented.
    address_address = 32'h12;
    net_in_valid = 1'b1; net_in_data = 32'h12; net_in_startofpacket = 1'b1;
    local_out_ready = 1'b1; fwd_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_local_valid", local_out_valid, 0);
    check("reset_fwd_valid", fwd_out_valid, 0);
    check("reset_drop_count", drop_count, 0);
    @(posedge clk); #1;
    net_in_valid = 1'b0; net_in_startofpacket = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 3-beat local packet
    rand_rdy = 1'b0;
    xmit(mk(32'h12, 1, 0, 0), 1, 0, c);
    xmit(mk(32'hA, 0, 0, 0), 1, 0, c);
    xmit(mk(32'hB, 0, 1, 1), 1, 0, c);
    cmp_queues("local3");

    // Forward packet with fwd_out_ready 1,0,1
    chk_mirror = 1'b1;
    lr_pat = '{1, 1, 1}; fr_pat = '{1, 0, 1};
    xmit(mk(32'h34, 1, 0, 0), 0, 1, c);
    xmit(mk(32'h55, 0, 1, 3), 0, 1, c);
    check("fwd_stall_cycles", 64'(c), 64'd2);
    chk_mirror = 1'b0;
    cmp_queues("fwd2");

    // Broadcast with forward sink stalled for two cycles
    bcast_active = 1'b1;
    lr_pat = '{1, 1, 1}; fr_pat = '{0, 0, 1};
    xmit(mk(32'hFFFFFFFF, 1, 0, 0), 1, 1, c);
    check("bcast_stall_cycles", 64'(c), 64'd3);
    xmit(mk(32'h77, 0, 1, 0), 1, 1, c);
    bcast_active = 1'b0;
    cmp_queues("bcast");
    check("bcast_lockstep", 64'(split_err), 64'd0);

    // Single-beat packet, then a normal header
    xmit(mk(32'h12, 1, 1, 2), 1, 0, c);
    xmit(mk(32'h34, 1, 0, 0), 0, 1, c);
    xmit(mk(32'h99, 0, 1, 0), 0, 1, c);
    cmp_queues("single");

    // Five headerless beats in IDLE
    for (int i = 0; i < 5; i++) send_drop(32'h100 + 32'(i));
    check_drops("drop5");
    cmp_queues("drop5");

    // Reset after two beats of a 4-beat local packet
    rand_rdy = 1'b1;
    xmit(mk(32'h12, 1, 0, 0), 1, 0, c);
    xmit(mk(32'h1, 0, 0, 0), 1, 0, c);
    net_in_valid = 1'b1; net_in_data = 32'h2; net_in_startofpacket = 1'b0; net_in_endofpacket = 1'b0;
    local_out_ready = 1'b1; fwd_out_ready = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_local_valid", local_out_valid, 0);
    check("midrst_fwd_valid", fwd_out_valid, 0);
    check("midrst_drop_count", drop_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    net_in_valid = 1'b0;
    model_drops = 0;
    send_drop(32'h2);
    send_drop(32'h3);
    check_drops("midrst");
    cmp_queues("midrst");

    // Random traffic with address changes mid-packet
    address_address = $urandom;
    for (int p = 0; p < 60; p++) begin
      kind = int'($urandom_range(0, 9));
      if (kind < 2) begin
        send_drop($urandom);
      end else begin
        case ($urandom_range(0, 2))
          0: hdr = address_address;
          1: hdr = 32'hFFFFFFFF;
          default: hdr = $urandom;
        endcase
        send_packet(hdr, int'($urandom_range(1, 5)), ($urandom_range(0, 3) == 0));
      end
      repeat ($urandom_range(0, 2)) begin
        drive_rdy();
        @(posedge clk); #1;
      end
    end
    cmp_queues("random");
    check_drops("random");
    check("random_bcast_lockstep", 64'(split_err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
